// File: rtl/rx_frame_builder.sv
// rx_frame_builder
// Collects a packet of bytes into a local buffer, then emits it as a frame:
// preamble byte (0x55 or 0xAA), 16-bit little-endian length, then the payload.
// Packets that do not fit in the buffer are discarded and flagged on o_drop.

module rx_frame_builder #(
    parameter int BUF_ADD_WIDTH = 8
) (
    input  logic       i_rx_clk,
    input  logic       i_rx_rst_n,
    input  logic       i_in_val,
    input  logic       i_in_sof,
    input  logic       i_in_eof,
    input  logic [7:0] i_in_data,
    output logic       o_in_rdy,
    input  logic       i_baud_sel,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic       o_tx_sof,
    input  logic       i_tx_rdy,
    output logic       o_busy,
    output logic       o_drop
);

    localparam int DEPTH = 2 ** BUF_ADD_WIDTH;

    // Length value meaning "buffer completely filled"; one more beat overflows.
    localparam logic [BUF_ADD_WIDTH:0] FULL_LEN = {1'b1, {BUF_ADD_WIDTH{1'b0}}};
    localparam logic [BUF_ADD_WIDTH:0] ONE_LEN  = {{BUF_ADD_WIDTH{1'b0}}, 1'b1};
    localparam logic [BUF_ADD_WIDTH:0] ZERO_LEN = '0;

    localparam logic [7:0] PRE_FAST = 8'h55;
    localparam logic [7:0] PRE_SLOW = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PRE,
        LEN_1,
        LEN_2,
        DATA
    } state_t;

    state_t                   state;
    logic [BUF_ADD_WIDTH:0]   length;
    logic [BUF_ADD_WIDTH-1:0] rd_addr;
    logic [BUF_ADD_WIDTH-1:0] rd_next;
    logic [7:0]               buffer [DEPTH];

    logic                     in_beat;
    logic                     out_beat;
    logic                     last_byte;
    logic [15:0]              length_ext;
    logic [7:0]               preamble;

    logic                     buf_we;
    logic [BUF_ADD_WIDTH-1:0] buf_wa;

    // Input is only accepted while collecting; the transmit phase ignores input.
    assign o_in_rdy   = (state == IDLE) || (state == LOAD);
    assign o_busy     = (state != IDLE);

    assign in_beat    = i_in_val && o_in_rdy;
    assign out_beat   = o_tx_valid && i_tx_rdy;

    assign rd_next    = rd_addr + 1'b1;
    assign last_byte  = ({1'b0, rd_addr} == (length - ONE_LEN));
    assign length_ext = 16'(length);
    assign preamble   = i_baud_sel ? PRE_FAST : PRE_SLOW;

    // Decide whether the current input beat lands in the buffer and where.
    always_comb begin
        buf_we = 1'b0;
        buf_wa = '0;
        if (in_beat) begin
            if (i_in_sof) begin
                buf_we = 1'b1;
                buf_wa = '0;
            end else if ((state == LOAD) && (length != FULL_LEN)) begin
                buf_we = 1'b1;
                buf_wa = length[BUF_ADD_WIDTH-1:0];
            end
        end
    end

    // Payload storage; contents are deliberately left untouched by reset.
    always_ff @(posedge i_rx_clk) begin
        if (buf_we) begin
            buffer[buf_wa] <= i_in_data;
        end
    end

    // Main FSM: collects the packet, then walks preamble/length/payload,
    // advancing only on accepted output beats so outputs hold during stalls.
    always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
        if (!i_rx_rst_n) begin
            state      <= IDLE;
            length     <= ZERO_LEN;
            rd_addr    <= '0;
            o_tx_valid <= 1'b0;
            o_tx_sof   <= 1'b0;
            o_tx_data  <= 8'h00;
            o_drop     <= 1'b0;
        end else begin
            o_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_beat && i_in_sof) begin
                        length <= ONE_LEN;
                        if (i_in_eof) begin
                            state      <= PRE;
                            o_tx_valid <= 1'b1;
                            o_tx_sof   <= 1'b1;
                            o_tx_data  <= preamble;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    if (in_beat) begin
                        if (i_in_sof) begin
                            // A new start abandons whatever was collected so far.
                            length <= ONE_LEN;
                            if (i_in_eof) begin
                                state      <= PRE;
                                o_tx_valid <= 1'b1;
                                o_tx_sof   <= 1'b1;
                                o_tx_data  <= preamble;
                            end
                        end else if (length == FULL_LEN) begin
                            o_drop <= 1'b1;
                            length <= ZERO_LEN;
                            state  <= IDLE;
                        end else begin
                            length <= length + ONE_LEN;
                            if (i_in_eof) begin
                                state      <= PRE;
                                o_tx_valid <= 1'b1;
                                o_tx_sof   <= 1'b1;
                                o_tx_data  <= preamble;
                            end
                        end
                    end
                end

                PRE: begin
                    if (out_beat) begin
                        state     <= LEN_1;
                        o_tx_sof  <= 1'b0;
                        o_tx_data <= length_ext[7:0];
                    end
                end

                LEN_1: begin
                    if (out_beat) begin
                        state     <= LEN_2;
                        o_tx_data <= length_ext[15:8];
                    end
                end

                LEN_2: begin
                    if (out_beat) begin
                        state     <= DATA;
                        rd_addr   <= '0;
                        o_tx_data <= buffer[0];
                    end
                end

                DATA: begin
                    if (out_beat) begin
                        if (last_byte) begin
                            state      <= IDLE;
                            rd_addr    <= '0;
                            o_tx_valid <= 1'b0;
                            o_tx_data  <= 8'h00;
                        end else begin
                            rd_addr   <= rd_next;
                            o_tx_data <= buffer[rd_next];
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    o_tx_valid <= 1'b0;
                    o_tx_sof   <= 1'b0;
                    o_tx_data  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_builder.sv
// Testbench for rx_frame_builder: two instances (8-bit and 4-bit buffer
// address), a shared input driver and a queue of expected output bytes.

module tb_rx_frame_builder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_val = 1'b0;
    logic       in_sof = 1'b0;
    logic       in_eof = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       baud = 1'b1;
    logic       tx_rdy = 1'b1;
    logic       sel = 1'b0;

    logic       val_a, val_b;
    logic       a_in_rdy, a_valid, a_sof, a_busy, a_drop;
    logic [7:0] a_data;
    logic       b_in_rdy, b_valid, b_sof, b_busy, b_drop;
    logic [7:0] b_data;

    logic       m_in_rdy, m_valid, m_sof, m_busy, m_drop;
    logic [7:0] m_data;

    logic [8:0] exp_q[$];
    logic [8:0] exp_v;
    logic [8:0] stall_val;
    logic [7:0] pkt [0:31];
    int         total = 0;
    int         bad = 0;
    int         drop_cnt = 0;
    int         beat_cnt = 0;
    int         beat_base;
    bit         mon_en = 1'b0;
    bit         stall_pend = 1'b0;
    bit         rand_rdy = 1'b0;

    always #5 clk = ~clk;

    assign val_a = in_val && !sel;
    assign val_b = in_val && sel;

    assign m_in_rdy = sel ? b_in_rdy : a_in_rdy;
    assign m_valid  = sel ? b_valid  : a_valid;
    assign m_sof    = sel ? b_sof    : a_sof;
    assign m_busy   = sel ? b_busy   : a_busy;
    assign m_drop   = sel ? b_drop   : a_drop;
    assign m_data   = sel ? b_data   : a_data;

    rx_frame_builder #(.BUF_ADD_WIDTH(8)) dut_a (
        .i_rx_clk   (clk),
        .i_rx_rst_n (rst_n),
        .i_in_val   (val_a),
        .i_in_sof   (in_sof),
        .i_in_eof   (in_eof),
        .i_in_data  (in_data),
        .o_in_rdy   (a_in_rdy),
        .i_baud_sel (baud),
        .o_tx_data  (a_data),
        .o_tx_valid (a_valid),
        .o_tx_sof   (a_sof),
        .i_tx_rdy   (tx_rdy),
        .o_busy     (a_busy),
        .o_drop     (a_drop)
    );

    rx_frame_builder #(.BUF_ADD_WIDTH(4)) dut_b (
        .i_rx_clk   (clk),
        .i_rx_rst_n (rst_n),
        .i_in_val   (val_b),
        .i_in_sof   (in_sof),
        .i_in_eof   (in_eof),
        .i_in_data  (in_data),
        .o_in_rdy   (b_in_rdy),
        .i_baud_sel (baud),
        .o_tx_data  (b_data),
        .o_tx_valid (b_valid),
        .o_tx_sof   (b_sof),
        .i_tx_rdy   (tx_rdy),
        .o_busy     (b_busy),
        .o_drop     (b_drop)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Downstream ready: held high, or toggled pseudo-randomly for stall tests.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every output beat and checks
    // that held data does not move while downstream is stalled.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_drop) drop_cnt++;
            if (stall_pend) checkOutput("stall_stable", {23'd0, m_sof, m_data}, {23'd0, stall_val});
            stall_pend = 1'b0;
            if (m_valid && tx_rdy) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    checkOutput("tx_byte", {23'd0, m_sof, m_data}, {23'd0, exp_v});
                end
            end else if (m_valid) begin
                stall_pend = 1'b1;
                stall_val  = {m_sof, m_data};
            end else begin
                checkOutput("idle_out", {23'd0, m_sof, m_data}, 32'd0);
            end
        end
    end

    task automatic driveBeat(input logic [7:0] d, input logic s, input logic e);
        checkOutput("in_rdy_beat", {31'd0, m_in_rdy}, 32'd1);
        in_data = d;
        in_sof  = s;
        in_eof  = e;
        in_val  = 1'b1;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
    endtask

    task automatic pushFrame(input int n, input logic b);
        logic [15:0] len16;
        len16 = 16'(n);
        exp_q.push_back({1'b1, (b ? 8'h55 : 8'hAA)});
        exp_q.push_back({1'b0, len16[7:0]});
        exp_q.push_back({1'b0, len16[15:8]});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, pkt[i]});
    endtask

    task automatic applyStimulus(input int n, input logic b, input bit drop_expected);
        baud = b;
        if (!drop_expected) pushFrame(n, b);
        for (int i = 0; i < n; i++) driveBeat(pkt[i], (i == 0), (i == n - 1));
        checkOutput("in_rdy_after_eof", {31'd0, m_in_rdy}, drop_expected ? 32'd1 : 32'd0);
        baud = ~b;
    endtask

    task automatic waitDrain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        checkOutput("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("in_rdy_idle", {31'd0, m_in_rdy}, 32'd1);
        checkOutput("busy_idle", {31'd0, m_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_rdy", {31'd0, a_in_rdy}, 32'd1);
        checkOutput("rst_valid", {31'd0, a_valid}, 32'd0);
        checkOutput("rst_sof", {31'd0, a_sof}, 32'd0);
        checkOutput("rst_data", {24'd0, a_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, a_busy}, 32'd0);
        checkOutput("rst_drop", {31'd0, a_drop}, 32'd0);
        checkOutput("rst_in_rdy_b", {31'd0, b_in_rdy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        $display("[TB] three-byte packet, fast preamble");
        pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
        applyStimulus(3, 1'b1, 1'b0);
        waitDrain();

        $display("[TB] single-byte packet, slow preamble");
        pkt[0] = 8'hA5;
        applyStimulus(1, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] beats without sof in idle are discarded");
        driveBeat(8'h77, 1'b0, 1'b0);
        driveBeat(8'h78, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_discard_busy", {31'd0, m_busy}, 32'd0);

        $display("[TB] restart mid-packet");
        driveBeat(8'h01, 1'b1, 1'b0);
        driveBeat(8'h02, 1'b0, 1'b0);
        pkt[0] = 8'h09;
        applyStimulus(1, 1'b1, 1'b0);
        waitDrain();

        $display("[TB] twenty bytes with random downstream stalls");
        for (int i = 0; i < 20; i++) pkt[i] = 8'($urandom_range(0, 255));
        rand_rdy  = 1'b1;
        beat_base = beat_cnt;
        applyStimulus(20, 1'b1, 1'b0);
        waitDrain();
        checkOutput("beat_count", beat_cnt - beat_base, 32'd23);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] small buffer overflow then full-size packet");
        sel = 1'b1;
        drop_cnt = 0;
        for (int i = 0; i < 17; i++) pkt[i] = 8'(8'h40 + i);
        applyStimulus(17, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("drop_count", drop_cnt, 32'd1);
        checkOutput("drop_busy", {31'd0, m_busy}, 32'd0);
        for (int i = 0; i < 16; i++) pkt[i] = 8'(8'hC0 + i);
        applyStimulus(16, 1'b0, 1'b0);
        waitDrain();
        checkOutput("drop_count_after", drop_cnt, 32'd1);
        sel = 1'b0;

        $display("[TB] reset during payload");
        for (int i = 0; i < 20; i++) pkt[i] = 8'(8'h80 + i);
        applyStimulus(20, 1'b1, 1'b0);
        k = 0;
        while (exp_q.size() > 10 && k < 200) begin
            @(posedge clk);
            k++;
        end
        checkOutput("reach_data", {31'd0, (exp_q.size() <= 10)}, 32'd1);
        #1;
        mon_en = 1'b0;
        stall_pend = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("midrst_data", {24'd0, m_data}, 32'd0);
        checkOutput("midrst_in_rdy", {31'd0, m_in_rdy}, 32'd1);
        checkOutput("midrst_busy", {31'd0, m_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        checkOutput("postrst_in_rdy", {31'd0, m_in_rdy}, 32'd1);
        pkt[0] = 8'hC1; pkt[1] = 8'hC2; pkt[2] = 8'hC3;
        applyStimulus(3, 1'b0, 1'b0);
        waitDrain();

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
